pc_array: RTL and testbench
===========================

// Module: pc_array
// PURPOSE
//  Bank of NUM_SM independent PIO program counters: generalised width, per-channel wrap window.
//  Adds a registered wrap-event pulse and a per-channel restart.
//  Optional call/return stack, compiled in by macro.
//  Sits between each state machine's instruction decoder and the shared instruction memory read port.
// PARAMETERS
//  NUM_SM      4   number of state-machine channels
//  ADDR_W      5   program-address width; instruction memory holds 2**ADDR_W words
//  STACK_DEPTH 2   return-stack entries per channel (used only with PC_CALLSTACK_EN)
// PORTS
//  clk          in   1              system clock
//  reset        in   1              synchronous, active-high reset
//  penable      in   NUM_SM         per-channel enable
//  stalled      in   NUM_SM         per-channel stall; current instruction not retiring
//  imm          in   NUM_SM         immediate-exec retire; advances even if disabled or stalled
//  jmp          in   NUM_SM         take din[ch] as next PC
//  restart      in   NUM_SM         force PC to wrap_target[ch]
//  din          in   NUM_SM*ADDR_W  jump target, channel ch at [ch*ADDR_W +: ADDR_W]
//  wrap_target  in   NUM_SM*ADDR_W  wrap destination / restart address
//  pend         in   NUM_SM*ADDR_W  wrap source (last program address)
//  dout         out  NUM_SM*ADDR_W  PC for next fetch, same packing
//  wrapped      out  NUM_SM         1-cycle registered pulse: channel took a wrap
//  call         in   NUM_SM         [PC_CALLSTACK_EN] push return address, jump to din
//  ret          in   NUM_SM         [PC_CALLSTACK_EN] pop return address into PC
//  stk_err      out  NUM_SM         [PC_CALLSTACK_EN] sticky overflow/underflow flag
// BEHAVIOUR
//  Channels are fully independent; channel ch is described below.
//  adv = (penable & ~stalled) | imm.
//  seq = (index == pend) ? wrap_target : index + 1, modulo 2**ADDR_W (all-ones -> 0).
//  Registered index update, priority high to low:
//    reset          -> index = 0, wrapped = 0, stack empty, stk_err = 0
//    restart        -> index = wrap_target; wrapped = 0; stack cleared; stk_err kept; ignores adv
//    adv & ret      -> index = pop (stack function, below)
//    adv & call     -> push seq; index = din
//    adv & jmp      -> index = din
//    adv            -> index = seq; wrapped = (index == pend) for one cycle
//    otherwise      -> index holds; wrapped = 0
//  call/ret/jmp without adv: no effect, no stack change.
//  dout (combinational, zero latency) = the value index takes next edge.
//    Excludes reset and restart: if adv, the next-PC value above; else index.
//  dout = 0 in the cycle after reset.
//  pend < wrap_target is legal: wrap still fires only on equality.
//  A jump past pend runs sequentially to all-ones, then rolls to 0.
//  Jump into (din == pend) does not set wrapped; wrap fires on the next sequential retire.
//  Stack per channel: STACK_DEPTH entries, pointer 0..STACK_DEPTH.
//    Push on full: entry dropped, index = din, stk_err = 1.
//    Pop on empty: index = seq, stk_err = 1.
//    call & ret same cycle: ret wins, call ignored.
// CONFIGURATION
//  PC_CALLSTACK_EN defined:
//    call, ret, stk_err ports and the stacks exist as above.
//  PC_CALLSTACK_EN undefined:
//    ports absent, no stack storage.
//    Priority reduces to reset > restart > jmp > seq; otherwise identical.
// TESTING
//  1) reset=1 one cycle -> all dout = 0, wrapped = 0; ch0 adv, pend=3, wrap_target=1:
//     dout seq 1,2,3,1,2; wrapped pulses one cycle after each 3->1 edge.
//  2) ch1 stalled=1 with penable=1 for 3 cycles -> index frozen; imm=1 while stalled -> advances by 1.
//  3) ADDR_W=5, ch2 jmp din=31, pend=10 -> next dout 0 (rollover), wrapped stays 0.
//  4) ch3 restart while jmp & adv, wrap_target=7 -> index=7; same cycle reset=1 -> index=0.
//  5) [PC_CALLSTACK_EN] at index 4, pend=9: call din=20 -> 20; ret -> 5.
//     3 calls at depth 2 -> third keeps jump, stk_err=1.
//  6) [PC_CALLSTACK_EN] ret on empty at index 9, pend=9, wrap_target=2 -> index=2, stk_err=1.
//     Other channels unaffected.

Source files
------------

// File: rtl/pc_array.sv
// Bank of NUM_SM independent program counters with per-channel wrap window, wrap pulse and restart.
// Optional per-channel call/return stack is compiled in with macro PC_CALLSTACK_EN.
module pc_array #(
  parameter int NUM_SM      = 4,
  parameter int ADDR_W      = 5
`ifdef PC_CALLSTACK_EN
  ,
  parameter int STACK_DEPTH = 2
`endif
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SM-1:0]          penable,
  input  logic [NUM_SM-1:0]          stalled,
  input  logic [NUM_SM-1:0]          imm,
  input  logic [NUM_SM-1:0]          jmp,
  input  logic [NUM_SM-1:0]          restart,
  input  logic [NUM_SM*ADDR_W-1:0]   din,
  input  logic [NUM_SM*ADDR_W-1:0]   wrap_target,
  input  logic [NUM_SM*ADDR_W-1:0]   pend,
  output logic [NUM_SM*ADDR_W-1:0]   dout,
  output logic [NUM_SM-1:0]          wrapped
`ifdef PC_CALLSTACK_EN
  ,
  input  logic [NUM_SM-1:0]          call,
  input  logic [NUM_SM-1:0]          ret,
  output logic [NUM_SM-1:0]          stk_err
`endif
);

`ifdef PC_CALLSTACK_EN
  localparam int SPW = $clog2(STACK_DEPTH + 1);
`endif

  for (genvar ch = 0; ch < NUM_SM; ch++) begin : g_ch
    logic [ADDR_W-1:0] r_index;
    logic              r_wrapped;
    logic [ADDR_W-1:0] w_din;
    logic [ADDR_W-1:0] w_wt;
    logic [ADDR_W-1:0] w_pend;
    logic [ADDR_W-1:0] w_seq;
    logic [ADDR_W-1:0] w_next;
    logic              w_adv;
    logic              w_at_end;
    logic              w_plain;

    assign w_din    = din[ch*ADDR_W +: ADDR_W];
    assign w_wt     = wrap_target[ch*ADDR_W +: ADDR_W];
    assign w_pend   = pend[ch*ADDR_W +: ADDR_W];
    assign w_adv    = (penable[ch] & ~stalled[ch]) | imm[ch];
    assign w_at_end = (r_index == w_pend);
    // Increment rolls all-ones over to zero naturally through truncation.
    assign w_seq    = w_at_end ? w_wt : r_index + 1'b1;

`ifdef PC_CALLSTACK_EN
    logic [ADDR_W-1:0] r_stack [STACK_DEPTH];
    logic [SPW-1:0]    r_sp;
    logic              r_err;
    logic [ADDR_W-1:0] w_top;
    logic              w_empty;
    logic              w_full;
    logic              w_do_ret;
    logic              w_do_call;

    assign w_empty   = (r_sp == '0);
    assign w_full    = (r_sp == SPW'(STACK_DEPTH));
    assign w_do_ret  = w_adv & ret[ch];
    assign w_do_call = w_adv & call[ch] & ~ret[ch];
    assign w_plain   = w_adv & ~ret[ch] & ~call[ch] & ~jmp[ch];

    // A pop on an empty stack falls back to the sequential address.
    always_comb begin
      w_top = w_seq;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (SPW'(i + 1) == r_sp) w_top = r_stack[i];
      end
    end

    always_comb begin
      w_next = r_index;
      if (w_do_ret)                          w_next = w_top;
      else if (w_do_call || (w_adv && jmp[ch])) w_next = w_din;
      else if (w_adv)                        w_next = w_seq;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        r_sp  <= '0;
        r_err <= 1'b0;
      end else if (restart[ch]) begin
        r_sp  <= '0;
      end else if (w_do_ret) begin
        if (w_empty) r_err <= 1'b1;
        else         r_sp  <= r_sp - 1'b1;
      end else if (w_do_call) begin
        if (w_full) begin
          r_err <= 1'b1;
        end else begin
          for (int i = 0; i < STACK_DEPTH; i++) begin
            if (SPW'(i) == r_sp) r_stack[i] <= w_seq;
          end
          r_sp <= r_sp + 1'b1;
        end
      end
    end

    assign stk_err[ch] = r_err;
`else
    assign w_plain = w_adv & ~jmp[ch];

    always_comb begin
      w_next = r_index;
      if (w_adv) w_next = jmp[ch] ? w_din : w_seq;
    end
`endif

    always_ff @(posedge clk) begin
      if (reset) begin
        r_index   <= '0;
        r_wrapped <= 1'b0;
      end else if (restart[ch]) begin
        r_index   <= w_wt;
        r_wrapped <= 1'b0;
      end else begin
        r_index   <= w_next;
        r_wrapped <= w_plain & w_at_end;
      end
    end

    assign dout[ch*ADDR_W +: ADDR_W] = w_next;
    assign wrapped[ch]               = r_wrapped;
  end

endmodule

// File: tb/tb_pc_array.sv
// Self-checking bench for pc_array: directed scenarios plus randomized traffic against a queue-based model.
// Stack scenarios are included when PC_CALLSTACK_EN is defined.
module tb_pc_array;
  localparam int N  = 4;
  localparam int AW = 5;
  localparam int SD = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    penable, stalled, imm, jmp, restart, call, ret;
  logic [N*AW-1:0] din, wrap_target, pend;
  logic [N*AW-1:0] dout;
  logic [N-1:0]    wrapped;
  logic [N-1:0]    stk_err;

  int total = 0;
  int bad   = 0;

  // Reference state: PC per channel, last wrap pulse, error flag, return stack as a queue.
  logic [AW-1:0] m_idx [N];
  logic          m_wr  [N];
  logic          m_err [N];
  logic [AW-1:0] m_stk [N][$];

  always #5 clk = ~clk;

  pc_array #(.NUM_SM(N), .ADDR_W(AW)
`ifdef PC_CALLSTACK_EN
    , .STACK_DEPTH(SD)
`endif
  ) dut (
    .clk(clk), .reset(reset), .penable(penable), .stalled(stalled), .imm(imm),
    .jmp(jmp), .restart(restart), .din(din), .wrap_target(wrap_target), .pend(pend),
    .dout(dout), .wrapped(wrapped)
`ifdef PC_CALLSTACK_EN
    , .call(call), .ret(ret), .stk_err(stk_err)
`endif
  );

`ifndef PC_CALLSTACK_EN
  assign stk_err = '0;
`endif

  function automatic logic [AW-1:0] fld(logic [N*AW-1:0] v, int ch);
    return v[ch*AW +: AW];
  endfunction

  function automatic logic m_adv(int ch);
    return (penable[ch] & ~stalled[ch]) | imm[ch];
  endfunction

  function automatic logic [AW-1:0] m_seq(int ch);
    int nxt;
    if (m_idx[ch] == fld(pend, ch)) return fld(wrap_target, ch);
    nxt = (int'(m_idx[ch]) + 1) % (1 << AW);
    return AW'(nxt);
  endfunction

  // Next fetch address as seen on dout (reset and restart are not reflected there).
  function automatic logic [AW-1:0] m_dout(int ch);
    if (!m_adv(ch)) return m_idx[ch];
    if (ret[ch]) return (m_stk[ch].size() == 0) ? m_seq(ch) : m_stk[ch][$];
    if (call[ch] || jmp[ch]) return fld(din, ch);
    return m_seq(ch);
  endfunction

  task automatic step();
    logic [AW-1:0] nxt, sq;
    logic          a;
    @(posedge clk);
    for (int ch = 0; ch < N; ch++) begin
      if (reset) begin
        m_idx[ch] = '0; m_wr[ch] = 1'b0; m_err[ch] = 1'b0; m_stk[ch].delete();
      end else if (restart[ch]) begin
        m_idx[ch] = fld(wrap_target, ch); m_wr[ch] = 1'b0; m_stk[ch].delete();
      end else begin
        a   = m_adv(ch);
        nxt = m_dout(ch);
        sq  = m_seq(ch);
        m_wr[ch] = a && !ret[ch] && !call[ch] && !jmp[ch] && (m_idx[ch] == fld(pend, ch));
        if (a && ret[ch]) begin
          if (m_stk[ch].size() == 0) m_err[ch] = 1'b1;
          else void'(m_stk[ch].pop_back());
        end else if (a && call[ch]) begin
          if (m_stk[ch].size() == SD) m_err[ch] = 1'b1;
          else m_stk[ch].push_back(sq);
        end
        m_idx[ch] = nxt;
      end
    end
    #1;
  endtask

  task automatic clear_inputs();
    reset = 0; penable = '0; stalled = '0; imm = '0; jmp = '0; restart = '0;
    call = '0; ret = '0; din = '0; wrap_target = '0; pend = '0;
  endtask

  task automatic test_reset();
    penable = N'($urandom); imm = N'($urandom); din = (N*AW)'($urandom);
    pend = (N*AW)'($urandom); wrap_target = (N*AW)'($urandom);
    reset = 1;
    step();
    clear_inputs();
    #1;
    for (int ch = 0; ch < N; ch++) begin
      total++;
      if (fld(dout, ch) !== '0 || wrapped[ch] !== 1'b0 || m_dout(ch) !== '0) begin
        bad++;
        $display("FAIL reset ch%0d: dout=%0d wrapped=%b required dout=0 wrapped=0", ch, fld(dout, ch), wrapped[ch]);
      end
    end
  endtask

  task automatic test_wrap_seq();
    int exp_d [5] = '{1, 2, 3, 1, 2};
    int exp_w [5] = '{0, 0, 0, 1, 0};
    pend[0*AW +: AW] = 3; wrap_target[0*AW +: AW] = 1; penable[0] = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (fld(dout, 0) !== AW'(exp_d[i]) || m_dout(0) !== AW'(exp_d[i])) begin
        bad++;
        $display("FAIL wrap_seq dout step%0d: got %0d required %0d", i, fld(dout, 0), exp_d[i]);
      end
      step();
      total++;
      if (wrapped[0] !== exp_w[i][0] || m_wr[0] !== exp_w[i][0]) begin
        bad++;
        $display("FAIL wrap_seq pulse step%0d: got %b required %0d", i, wrapped[0], exp_w[i]);
      end
    end
    clear_inputs();
  endtask

  task automatic test_stall();
    logic [AW-1:0] start;
    start = m_idx[1];
    pend[1*AW +: AW] = 30; penable[1] = 1; stalled[1] = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (fld(dout, 1) !== start) begin
        bad++;
        $display("FAIL stall cycle%0d: dout=%0d required %0d", i, fld(dout, 1), start);
      end
      step();
    end
    imm[1] = 1;
    #1;
    total++;
    if (fld(dout, 1) !== start + 1'b1 || m_dout(1) !== start + 1'b1) begin
      bad++;
      $display("FAIL stall imm: dout=%0d required %0d", fld(dout, 1), start + 1'b1);
    end
    step();
    clear_inputs();
  endtask

  task automatic test_rollover();
    pend[2*AW +: AW] = 10; penable[2] = 1; jmp[2] = 1; din[2*AW +: AW] = 31;
    #1;
    total++;
    if (fld(dout, 2) !== 5'd31) begin
      bad++;
      $display("FAIL rollover jump: dout=%0d required 31", fld(dout, 2));
    end
    step();
    jmp[2] = 0;
    #1;
    total++;
    if (fld(dout, 2) !== 5'd0 || m_dout(2) !== 5'd0) begin
      bad++;
      $display("FAIL rollover next: dout=%0d required 0", fld(dout, 2));
    end
    step();
    total++;
    if (wrapped[2] !== 1'b0 || m_wr[2] !== 1'b0) begin
      bad++;
      $display("FAIL rollover pulse: wrapped=%b required 0", wrapped[2]);
    end
    clear_inputs();
  endtask

  task automatic test_restart();
    wrap_target[3*AW +: AW] = 7; restart[3] = 1; jmp[3] = 1; penable[3] = 1; din[3*AW +: AW] = 20;
    step();
    clear_inputs();
    wrap_target[3*AW +: AW] = 7;
    #1;
    total++;
    if (fld(dout, 3) !== 5'd7 || m_idx[3] !== 5'd7) begin
      bad++;
      $display("FAIL restart: index=%0d required 7", fld(dout, 3));
    end
    restart[3] = 1; reset = 1; penable[3] = 1;
    step();
    clear_inputs();
    #1;
    total++;
    if (fld(dout, 3) !== 5'd0 || m_idx[3] !== 5'd0) begin
      bad++;
      $display("FAIL restart_vs_reset: index=%0d required 0", fld(dout, 3));
    end
  endtask

`ifdef PC_CALLSTACK_EN
  task automatic test_call_ret();
    int dins [3] = '{21, 22, 23};
    wrap_target[0*AW +: AW] = 4; restart[0] = 1;
    step();
    restart[0] = 0; pend[0*AW +: AW] = 9; penable[0] = 1; call[0] = 1; din[0*AW +: AW] = 20;
    #1;
    total++;
    if (fld(dout, 0) !== 5'd20) begin
      bad++;
      $display("FAIL call: dout=%0d required 20", fld(dout, 0));
    end
    step();
    call[0] = 0; ret[0] = 1;
    #1;
    total++;
    if (fld(dout, 0) !== 5'd5 || m_dout(0) !== 5'd5) begin
      bad++;
      $display("FAIL ret: dout=%0d required 5", fld(dout, 0));
    end
    step();
    ret[0] = 0; call[0] = 1;
    for (int i = 0; i < 3; i++) begin
      din[0*AW +: AW] = AW'(dins[i]);
      #1;
      total++;
      if (fld(dout, 0) !== AW'(dins[i])) begin
        bad++;
        $display("FAIL call_depth%0d: dout=%0d required %0d", i, fld(dout, 0), dins[i]);
      end
      step();
      total++;
      if (stk_err[0] !== (i == 2) || m_err[0] !== (i == 2)) begin
        bad++;
        $display("FAIL overflow flag%0d: stk_err=%b required %0d", i, stk_err[0], (i == 2));
      end
    end
    clear_inputs();
    #1;
    total++;
    if (fld(dout, 0) !== 5'd23) begin
      bad++;
      $display("FAIL overflow keeps jump: index=%0d required 23", fld(dout, 0));
    end
  endtask

  task automatic test_ret_empty();
    wrap_target[1*AW +: AW] = 9; restart[1] = 1;
    step();
    restart[1] = 0; wrap_target[1*AW +: AW] = 2; pend[1*AW +: AW] = 9; penable[1] = 1; ret[1] = 1;
    #1;
    total++;
    if (fld(dout, 1) !== 5'd2 || m_dout(1) !== 5'd2) begin
      bad++;
      $display("FAIL ret_empty: dout=%0d required 2", fld(dout, 1));
    end
    step();
    total++;
    if (stk_err[1] !== 1'b1) begin
      bad++;
      $display("FAIL underflow flag: stk_err=%b required 1", stk_err[1]);
    end
    clear_inputs();
    #1;
    for (int ch = 2; ch < N; ch++) begin
      total++;
      if (stk_err[ch] !== m_err[ch] || fld(dout, ch) !== m_idx[ch]) begin
        bad++;
        $display("FAIL isolation ch%0d: stk_err=%b index=%0d required %b %0d", ch, stk_err[ch], fld(dout, ch), m_err[ch], m_idx[ch]);
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc % 40 == 0) begin
        for (int ch = 0; ch < N; ch++) begin
          pend[ch*AW +: AW]        = AW'($urandom_range(2, 20));
          wrap_target[ch*AW +: AW] = AW'($urandom_range(0, 24));
        end
      end
      reset = ($urandom_range(0, 99) == 0);
      for (int ch = 0; ch < N; ch++) begin
        penable[ch] = ($urandom_range(0, 3) != 0);
        stalled[ch] = ($urandom_range(0, 3) == 0);
        imm[ch]     = ($urandom_range(0, 9) == 0);
        jmp[ch]     = ($urandom_range(0, 9) == 0);
        restart[ch] = ($urandom_range(0, 24) == 0);
        din[ch*AW +: AW] = AW'($urandom);
`ifdef PC_CALLSTACK_EN
        call[ch] = ($urandom_range(0, 7) == 0);
        ret[ch]  = ($urandom_range(0, 7) == 0);
`endif
      end
      #1;
      for (int ch = 0; ch < N; ch++) begin
        total++;
        if (fld(dout, ch) !== m_dout(ch)) begin
          bad++;
          $display("FAIL random dout cyc%0d ch%0d: got %0d required %0d", cyc, ch, fld(dout, ch), m_dout(ch));
        end
      end
      step();
      for (int ch = 0; ch < N; ch++) begin
        total++;
        if (wrapped[ch] !== m_wr[ch]) begin
          bad++;
          $display("FAIL random wrapped cyc%0d ch%0d: got %b required %b", cyc, ch, wrapped[ch], m_wr[ch]);
        end
`ifdef PC_CALLSTACK_EN
        total++;
        if (stk_err[ch] !== m_err[ch]) begin
          bad++;
          $display("FAIL random stk_err cyc%0d ch%0d: got %b required %b", cyc, ch, stk_err[ch], m_err[ch]);
        end
`endif
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    for (int ch = 0; ch < N; ch++) begin
      m_idx[ch] = '0; m_wr[ch] = 1'b0; m_err[ch] = 1'b0;
    end
    test_reset();
    test_wrap_seq();
    test_stall();
    test_rollover();
    test_restart();
`ifdef PC_CALLSTACK_EN
    test_call_ret();
    test_ret_empty();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
